ambiente_robo: RTL and testbench
================================

# ambiente_robo

Synthesizable grid-world responder for the maze robot: consumes the controller's single-cycle commands (`avancar`, `girar`, `remover`) and returns the sensor signals the controller reads (`head`, `left`, `under`, `barreira`). Holds robot position, heading and a debris bitmap for a fixed 8x8 maze. It sits opposite `Sensores`/`avanco` in system benches and closes the control loop in simulation and on FPGA.

## Interface
- `X0`, default 0: start column (0-7).
- `Y0`, default 0: start row (0-7).
- `ORI0`, default 0: start heading (0=N, 1=E, 2=S, 3=W).
- `XF`, default 7: goal column.
- `YF`, default 7: goal row.
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low.
- `avancar`  in  1  command pulse: move one cell forward.
- `girar`  in  1  command pulse: rotate 90° clockwise.
- `remover`  in  1  command pulse: clear debris.
- `head`  out  1  wall or maze border directly ahead.
- `left`  out  1  wall or maze border on robot's left.
- `under`  out  1  debris in current cell.
- `barreira`  out  1  debris in cell ahead (0 if `head`=1).
- `pos_x`, `pos_y`  out  3  current cell; x grows east, y grows north.
- `orientacao`  out  3  heading, codes 0-3; 4-7 never driven.
- `ocupado`  out  1  command in progress; new commands ignored.
- `colisao`  out  1  one-cycle pulse: blocked `avancar`.
- `cmd_perdido`  out  1  one-cycle pulse: command dropped.
- `fim`  out  1  level: (`pos_x`,`pos_y`)==(XF,YF).

## Operation
- FSM states: OCIOSO, EXEC, SENS.
- OCIOSO: any command bit high → EXEC, `ocupado`=1. Multiple bits: priority `remover` > `girar` > `avancar`; lower ones dropped with `cmd_perdido` pulse.
- EXEC: apply latched command, → SENS.
  - `girar`: ori = (ori+1) mod 4.
  - `avancar`: if `head`=1 or `barreira`=1 → `colisao` pulse, no move; else step N:y+1, E:x+1, S:y-1, W:x-1.
  - `remover`: if `barreira`=1 clear debris of cell ahead; else if `under`=1 clear current cell; else no-op.
- SENS: recompute all four sensors from new pos/ori/debris, → OCIOSO, `ocupado`=0.
- Command high while `ocupado`=1 → ignored, `cmd_perdido` pulse same edge.
- Walls: per-cell 4-bit {N,E,S,W} from package. Border sides always walls regardless of table; no coordinate ever wraps.
- Debris: 64-bit register, cell index y*8+x, init from package; bits only cleared, never set.
- `fim` registered, updates with position; no effect on accepting commands.

## Timing
- Reset (async assert): pos=(X0,Y0), ori=ORI0, debris=package init, state=SENS, `ocupado`=1, sensors=0, `colisao`=`cmd_perdido`=0, `fim` = start==goal.
- First edge after reset release: sensors valid, `ocupado`=0.
- Command sampled at edge k (state OCIOSO): `ocupado`=1 after k; pos/ori/debris and `colisao` after k+1; sensors after k+2 with `ocupado`=0. Earliest next accept: edge k+3.
- `colisao`, `cmd_perdido`: exactly one cycle high.
- Reset mid-command: aborts, all state to reset values; no partial update survives.
- All outputs registered; no combinational input→output path.

## Structure
- Package `robo_pkg`: heading encoding constants, FSM state enum, `PAREDES[64]` 4-bit wall table, `LIXO_INI` 64-bit debris map.
- Package map content includes: no wall between (0,0) and (1,0); debris at (1,0) only along row 0; goal (7,7) reachable.
- One combinational sub-module `calc_vizinho`: (pos, ori) → ahead-cell index, ahead-blocked, left-blocked. Shared by EXEC and SENS.

## Test plan
- Reset X0=Y0=0, ORI0=0 → after release edge: `ocupado` 1→0, pos (0,0), `orientacao`=0, `left`=1 (border).
- `girar` x4 from heading 0 → `orientacao` 1,2,3,0; each `ocupado` high exactly 2 cycles.
- Heading W at (0,0), `avancar` → `colisao` one cycle, pos stays (0,0), `head`=1.
- Heading E at (0,0): `barreira`=1; `avancar` → `colisao`; `remover` → `barreira`=0; `avancar` → pos (1,0), `under`=0.
- `girar`+`avancar` same cycle → rotate only, `cmd_perdido` pulse; command during `ocupado` → `cmd_perdido`, state unchanged.
- `reset` low during EXEC of `avancar` → pos (X0,Y0), debris restored, `ocupado`=1 then 0 after release.

Source files
------------

// File: rtl/robo_pkg.sv
// Shared definitions for the maze-robot grid world: headings, FSM states,
// command encoding, wall table and initial debris map for the 8x8 maze.
package robo_pkg;

  localparam int unsigned COORD_W = 3;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned N_CELLS = 64;

  localparam logic [1:0] ORI_N = 2'd0;
  localparam logic [1:0] ORI_E = 2'd1;
  localparam logic [1:0] ORI_S = 2'd2;
  localparam logic [1:0] ORI_W = 2'd3;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXEC   = 2'd1,
    SENS   = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    CMD_AVANCAR = 2'd0,
    CMD_GIRAR   = 2'd1,
    CMD_REMOVER = 2'd2
  } cmd_t;

  // Per-cell walls {N,E,S,W}, index y*8+x; borders are added by the neighbour logic.
  localparam logic [3:0] PAREDES [N_CELLS] = '{
    4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0
  };

  // Debris at (1,0), (2,2) and (5,4).
  localparam logic [N_CELLS-1:0] LIXO_INI = 64'h0000_0020_0004_0002;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/calc_vizinho.sv
// Neighbour lookup: from position and heading, gives the cell index ahead and
// whether the front and left sides are closed by a wall or the maze border.
module calc_vizinho
  import robo_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         ori,
  output logic [IDX_W-1:0]   idx_frente,
  output logic               bloq_frente,
  output logic               bloq_esq
);

  logic [3:0]         fechado;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;

  // Bits {N,E,S,W}; a border side is always closed so no coordinate wraps.
  always_comb begin
    fechado = PAREDES[cell_idx(x, y)] |
              {y == 3'd7, x == 3'd7, y == 3'd0, x == 3'd0};
    nx = x;
    ny = y;
    bloq_frente = 1'b0;
    bloq_esq    = 1'b0;
    case (ori)
      ORI_N: begin ny = y + 3'd1; bloq_frente = fechado[3]; bloq_esq = fechado[0]; end
      ORI_E: begin nx = x + 3'd1; bloq_frente = fechado[2]; bloq_esq = fechado[3]; end
      ORI_S: begin ny = y - 3'd1; bloq_frente = fechado[1]; bloq_esq = fechado[2]; end
      default: begin nx = x - 3'd1; bloq_frente = fechado[0]; bloq_esq = fechado[1]; end
    endcase
    idx_frente = cell_idx(nx, ny);
  end

endmodule

// File: rtl/ambiente_robo.sv
// Grid-world responder for the maze robot: executes avancar/girar/remover
// pulses and returns registered sensor readings for the controller.
module ambiente_robo
  import robo_pkg::*;
#(
  parameter int unsigned X0   = 0,
  parameter int unsigned Y0   = 0,
  parameter int unsigned ORI0 = 0,
  parameter int unsigned XF   = 7,
  parameter int unsigned YF   = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               avancar,
  input  logic               girar,
  input  logic               remover,
  output logic               head,
  output logic               left,
  output logic               under,
  output logic               barreira,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [2:0]         orientacao,
  output logic               ocupado,
  output logic               colisao,
  output logic               cmd_perdido,
  output logic               fim
);

  estado_t              estado;
  cmd_t                 cmd;
  logic [1:0]           ori;
  logic [N_CELLS-1:0]   lixo;
  logic [IDX_W-1:0]     idx_frente;
  logic [IDX_W-1:0]     idx_atual;
  logic                 bloq_frente;
  logic                 bloq_esq;
  logic                 algum_cmd;

  calc_vizinho u_vizinho (
    .x           (pos_x),
    .y           (pos_y),
    .ori         (ori),
    .idx_frente  (idx_frente),
    .bloq_frente (bloq_frente),
    .bloq_esq    (bloq_esq)
  );

  assign idx_atual  = cell_idx(pos_x, pos_y);
  assign algum_cmd  = avancar | girar | remover;
  assign orientacao = {1'b0, ori};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= SENS;
      cmd         <= CMD_GIRAR;
      pos_x       <= 3'(X0);
      pos_y       <= 3'(Y0);
      ori         <= 2'(ORI0);
      lixo        <= LIXO_INI;
      head        <= 1'b0;
      left        <= 1'b0;
      under       <= 1'b0;
      barreira    <= 1'b0;
      ocupado     <= 1'b1;
      colisao     <= 1'b0;
      cmd_perdido <= 1'b0;
      fim         <= (3'(X0) == 3'(XF)) && (3'(Y0) == 3'(YF));
    end else begin
      colisao     <= 1'b0;
      cmd_perdido <= 1'b0;
      case (estado)
        OCIOSO: begin
          // Accept one command; lower-priority bits in the same cycle are dropped.
          if (algum_cmd) begin
            ocupado <= 1'b1;
            estado  <= EXEC;
            if (remover) begin
              cmd         <= CMD_REMOVER;
              cmd_perdido <= girar | avancar;
            end else if (girar) begin
              cmd         <= CMD_GIRAR;
              cmd_perdido <= avancar;
            end else begin
              cmd         <= CMD_AVANCAR;
            end
          end
        end
        EXEC: begin
          cmd_perdido <= algum_cmd;
          estado      <= SENS;
          case (cmd)
            CMD_GIRAR: ori <= ori + 2'd1;
            CMD_AVANCAR: begin
              if (head || barreira) begin
                colisao <= 1'b1;
              end else begin
                pos_x <= idx_frente[2:0];
                pos_y <= idx_frente[5:3];
                fim   <= (idx_frente == cell_idx(3'(XF), 3'(YF)));
              end
            end
            default: begin
              if (barreira)   lixo[idx_frente] <= 1'b0;
              else if (under) lixo[idx_atual]  <= 1'b0;
            end
          endcase
        end
        SENS: begin
          // Sensors always reflect the post-command position, heading and debris.
          cmd_perdido <= algum_cmd;
          head        <= bloq_frente;
          left        <= bloq_esq;
          under       <= lixo[idx_atual];
          barreira    <= !bloq_frente && lixo[idx_frente];
          ocupado     <= 1'b0;
          estado      <= OCIOSO;
        end
        default: begin
          estado  <= SENS;
          ocupado <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ambiente_robo.sv
// Directed bench for ambiente_robo: walks the robot through turns, collisions,
// debris removal, dropped commands and a mid-command reset.
module tb_ambiente_robo;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       avancar  = 1'b0;
  logic       girar    = 1'b0;
  logic       remover  = 1'b0;
  logic       head, left, under, barreira;
  logic [2:0] pos_x, pos_y, orientacao;
  logic       ocupado, colisao, cmd_perdido, fim;

  int vectors     = 0;
  int miscompares = 0;

  logic b0, p0, b1, c1, p1, b2, c2;

  always #5 clock = ~clock;

  ambiente_robo #(.X0(0), .Y0(0), .ORI0(0), .XF(1), .YF(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .avancar     (avancar),
    .girar       (girar),
    .remover     (remover),
    .head        (head),
    .left        (left),
    .under       (under),
    .barreira    (barreira),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .orientacao  (orientacao),
    .ocupado     (ocupado),
    .colisao     (colisao),
    .cmd_perdido (cmd_perdido),
    .fim         (fim)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input logic a, input logic g, input logic r);
    @(negedge clock);
    avancar = a; girar = g; remover = r;
    @(posedge clock); #1;
    avancar = 1'b0; girar = 1'b0; remover = 1'b0;
  endtask

  // Samples after accept edge k, then k+1 and k+2.
  task automatic run(input logic a, input logic g, input logic r);
    issue(a, g, r);
    b0 = ocupado; p0 = cmd_perdido;
    @(posedge clock); #1;
    b1 = ocupado; c1 = colisao; p1 = cmd_perdido;
    @(posedge clock); #1;
    b2 = ocupado; c2 = colisao;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ocupado && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    check("idle_timeout", 8'(ocupado), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ocupado", 8'(ocupado), 8'd1);
    check("rst_pos", 8'({pos_y, pos_x}), 8'd0);
    check("rst_sens", 8'({head, left, under, barreira}), 8'd0);
    check("rst_fim", 8'(fim), 8'd0);

    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("rel_ocupado", 8'(ocupado), 8'd0);
    check("rel_ori", 8'(orientacao), 8'd0);
    check("rel_left", 8'(left), 8'd1);
    check("rel_head", 8'(head), 8'd0);

    for (int i = 1; i <= 3; i++) begin
      run(1'b0, 1'b1, 1'b0);
      check("gir_busy", 8'({b0, b1, b2}), 8'b110);
      check("gir_ori", 8'(orientacao), 8'(i));
      if (i == 1) check("gir_e_barreira", 8'(barreira), 8'd1);
      if (i == 2) check("gir_s_head", 8'(head), 8'd1);
    end
    check("w_head_left", 8'({head, left}), 8'b11);

    run(1'b1, 1'b0, 1'b0);
    check("w_colisao", 8'({c1, c2}), 8'b10);
    check("w_pos", 8'({pos_y, pos_x}), 8'd0);
    check("w_head", 8'(head), 8'd1);

    run(1'b0, 1'b1, 1'b0);
    check("gir4_ori", 8'(orientacao), 8'd0);
    check("gir4_busy", 8'({b0, b1, b2}), 8'b110);
    run(1'b0, 1'b1, 1'b0);
    check("e_barreira", 8'(barreira), 8'd1);

    run(1'b1, 1'b0, 1'b0);
    check("e_colisao", 8'(c1), 8'd1);
    check("e_pos_blocked", 8'({pos_y, pos_x}), 8'd0);

    run(1'b0, 1'b0, 1'b1);
    check("rem_barreira", 8'({barreira, under, c1}), 8'd0);

    run(1'b1, 1'b0, 1'b0);
    check("mov_colisao", 8'(c1), 8'd0);
    check("mov_pos", 8'({pos_y, pos_x}), 8'd1);
    check("mov_under_head", 8'({under, head}), 8'd0);

    run(1'b1, 1'b1, 1'b0);
    check("multi_perdido", 8'({p0, p1}), 8'b10);
    check("multi_ori", 8'(orientacao), 8'd2);
    check("multi_pos", 8'({pos_y, pos_x}), 8'd1);

    issue(1'b0, 1'b1, 1'b0);
    avancar = 1'b1;
    @(posedge clock); #1;
    check("busy_perdido", 8'(cmd_perdido), 8'd1);
    avancar = 1'b0;
    @(posedge clock); #1;
    check("busy_perdido_end", 8'({ocupado, cmd_perdido}), 8'd0);
    check("busy_ori", 8'(orientacao), 8'd3);
    check("busy_pos", 8'({pos_y, pos_x}), 8'd1);

    run(1'b0, 1'b1, 1'b0);
    run(1'b1, 1'b0, 1'b0);
    check("n_pos", 8'({pos_y, pos_x}), 8'd9);
    check("n_fim", 8'(fim), 8'd1);

    issue(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_pos", 8'({pos_y, pos_x}), 8'd0);
    check("mid_rst_ocupado", 8'(ocupado), 8'd1);
    check("mid_rst_ori_fim", 8'({orientacao, fim}), 8'd0);
    @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rel_ocupado", 8'(ocupado), 8'd0);
    run(1'b0, 1'b1, 1'b0);
    check("debris_restored", 8'(barreira), 8'd1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
